axilite_master: RTL

- AXI4-Lite initiator that turns single-beat commands from a local command/response interface into AXI4-Lite write or read transactions.
- It sits on the bus side opposite the team's AXI4-Lite register slave and is used by on-chip sequencers and test logic to access register banks.
- One transaction is outstanding at a time.
- A watchdog recovers from dead or absent slaves.

---
 rtl/axilite_master.sv | 130 +++++++++++++
 1 files changed

// File: rtl/axilite_master.sv
// AXI4-Lite initiator: turns single-beat local commands into AXI4-Lite
// write/read transactions, one outstanding, with a watchdog abort for dead slaves.
module axilite_master #(
  parameter int AXI_ADDRESS_WIDTH = 16,
  parameter int REQ_TIMEOUT       = 64
) (
  input  logic                         AXI_ACLK,
  input  logic                         AXI_RESET,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [AXI_ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [31:0]                  cmd_wdata,
  input  logic [3:0]                   cmd_wstrb,
  output logic                         rsp_valid,
  output logic                         rsp_write,
  output logic [31:0]                  rsp_rdata,
  output logic [1:0]                   rsp_resp,
  output logic                         rsp_timeout,
  output logic                         AXI_AWVALID,
  output logic [AXI_ADDRESS_WIDTH-1:0] AXI_AWADDR,
  input  logic                         AXI_AWREADY,
  output logic                         AXI_WVALID,
  output logic [31:0]                  AXI_WDATA,
  output logic [3:0]                   AXI_WSTRB,
  input  logic                         AXI_WREADY,
  input  logic                         AXI_BVALID,
  input  logic [1:0]                   AXI_BRESP,
  output logic                         AXI_BREADY,
  output logic                         AXI_ARVALID,
  output logic [AXI_ADDRESS_WIDTH-1:0] AXI_ARADDR,
  input  logic                         AXI_ARREADY,
  input  logic                         AXI_RVALID,
  input  logic [31:0]                  AXI_RDATA,
  input  logic [1:0]                   AXI_RRESP,
  output logic                         AXI_RREADY
);

  localparam int TW = $clog2(REQ_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

  state_t                         state, next;
  logic [AXI_ADDRESS_WIDTH-1:0]   addr_q;
  logic [31:0]                    wdata_q;
  logic [3:0]                     wstrb_q;
  logic                           aw_done, w_done;
  logic [TW-1:0]                  wdog;
  logic                           aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic                           busy, expire, abort;

  // VALID/READY decode straight from state so an async reset drops them at once
  assign cmd_ready   = (state == IDLE);
  assign AXI_AWVALID = (state == WR_REQ) && !aw_done;
  assign AXI_WVALID  = (state == WR_REQ) && !w_done;
  assign AXI_BREADY  = (state == WR_RESP);
  assign AXI_ARVALID = (state == RD_REQ);
  assign AXI_RREADY  = (state == RD_RESP);
  assign rsp_valid   = (state == DONE);

  assign AXI_AWADDR = addr_q;
  assign AXI_ARADDR = addr_q;
  assign AXI_WDATA  = wdata_q;
  assign AXI_WSTRB  = wstrb_q;

  assign aw_hs = AXI_AWVALID && AXI_AWREADY;
  assign w_hs  = AXI_WVALID  && AXI_WREADY;
  assign ar_hs = AXI_ARVALID && AXI_ARREADY;
  assign b_hs  = AXI_BREADY  && AXI_BVALID;
  assign r_hs  = AXI_RREADY  && AXI_RVALID;

  assign busy   = (state == WR_REQ) || (state == WR_RESP) || (state == RD_REQ) || (state == RD_RESP);
  // expiry fires in the cycle the counter would reach REQ_TIMEOUT; a final handshake then still wins
  assign expire = busy && (wdog == TW'(REQ_TIMEOUT - 1));
  assign abort  = expire && !(b_hs || r_hs);

  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) state <= IDLE;
    else           state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (cmd_valid) next = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ:  if (expire) next = DONE;
               else if ((aw_done || aw_hs) && (w_done || w_hs)) next = WR_RESP;
      WR_RESP: if (b_hs || expire) next = DONE;
      RD_REQ:  if (expire) next = DONE;
               else if (ar_hs) next = RD_RESP;
      RD_RESP: if (r_hs || expire) next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      wdog        <= '0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        addr_q  <= cmd_addr & ~(AXI_ADDRESS_WIDTH'(3));
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        wdog    <= '0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (busy)  wdog    <= wdog + 1'b1;
      if (busy && next == DONE) begin
        rsp_write   <= (state == WR_REQ) || (state == WR_RESP);
        rsp_timeout <= abort;
        rsp_resp    <= abort ? 2'b10 : ((state == WR_RESP) ? AXI_BRESP : AXI_RRESP);
        rsp_rdata   <= (state == RD_RESP && !abort) ? AXI_RDATA : 32'h0;
      end
    end
  end

endmodule
